// File: rtl/riscv_types.sv
`default_nettype none
// riscv_types: shared RV32M divider types, operand-prep entry layout and helpers.
// Revision 1.0
package riscv_types;

  localparam int DIV_CLZ_W = 5;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } fn3_mul_div_t;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic [3:0] id;
  } div_attributes_t;

  typedef struct packed {
    logic [31:0]          unsigned_dividend;
    logic [31:0]          unsigned_divisor;
    logic [DIV_CLZ_W-1:0] dividend_CLZ;
    logic [DIV_CLZ_W-1:0] divisor_CLZ;
    logic                 divisor_is_zero;
    logic                 reuse_result;
    fn3_mul_div_t         fn3;
    div_attributes_t      attr;
  } div_fifo_inputs_t;

  // Negative signed operands become their magnitude; 0x80000000 maps to itself.
  function automatic logic [31:0] abs_if_signed(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clz32.sv
`default_nettype none
// clz32: combinational 32-bit leading-zero count; an all-zero input saturates to 31.
// Revision 1.0
module clz32
  import riscv_types::*;
(
  input  logic [31:0]          value,
  output logic [DIV_CLZ_W-1:0] count
);

  // Scanning upward lets the highest set bit win; zero keeps the saturated default.
  always_comb begin
    count = DIV_CLZ_W'(31);
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = DIV_CLZ_W'(31 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_operand_prep.sv
`default_nettype none
// div_operand_prep: preconditions RV32M divide operands and queues them for the divider core.
// Revision 1.0
module div_operand_prep
  import riscv_types::*;
#(
  parameter int DEPTH        = 2,
  parameter int ENABLE_REUSE = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic [2:0]                           issue_fn3,
  input  logic [31:0]                          issue_rs1,
  input  logic [31:0]                          issue_rs2,
  input  logic [$bits(div_attributes_t)-1:0]   issue_attr,
  input  logic                                 rs_write,
  input  logic                                 flush,
  output logic                                 fifo_valid,
  input  logic                                 fifo_pop,
  output logic [$bits(div_fifo_inputs_t)-1:0]  fifo_data
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = $bits(div_fifo_inputs_t);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic        reuse_valid;
  logic [31:0] reuse_rs1;
  logic [31:0] reuse_rs2;
  logic        reuse_signed;

  logic full;
  logic empty;
  logic accept;
  logic pop_take;
  logic is_signed;
  logic reuse_hit;

  logic [31:0]          abs_rs1;
  logic [31:0]          abs_rs2;
  logic [DIV_CLZ_W-1:0] clz_rs1;
  logic [DIV_CLZ_W-1:0] clz_rs2;

  div_fifo_inputs_t new_entry;

  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign issue_ready = !full || fifo_pop;
  assign accept      = issue_valid && issue_ready && !flush;
  assign pop_take    = fifo_pop && !empty && !flush;
  assign fifo_valid  = !empty;
  assign fifo_data   = mem[rd_ptr];

  assign is_signed = !issue_fn3[0];
  assign abs_rs1   = abs_if_signed(issue_rs1, is_signed);
  assign abs_rs2   = abs_if_signed(issue_rs2, is_signed);

  clz32 u_clz_dividend (
    .value (abs_rs1),
    .count (clz_rs1)
  );

  clz32 u_clz_divisor (
    .value (abs_rs2),
    .count (clz_rs2)
  );

  // Compared against the stored operands as they were before this cycle's accept.
  assign reuse_hit = (ENABLE_REUSE != 0) && reuse_valid &&
                     (issue_rs1 == reuse_rs1) && (issue_rs2 == reuse_rs2) &&
                     (is_signed == reuse_signed);

  always_comb begin
    new_entry                   = '0;
    new_entry.unsigned_dividend = abs_rs1;
    new_entry.unsigned_divisor  = abs_rs2;
    new_entry.dividend_CLZ      = clz_rs1;
    new_entry.divisor_CLZ       = clz_rs2;
    new_entry.divisor_is_zero   = (issue_rs2 == 32'd0);
    new_entry.reuse_result      = reuse_hit;
    new_entry.fn3               = fn3_mul_div_t'(issue_fn3);
    new_entry.attr              = div_attributes_t'(issue_attr);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr]  <= new_entry;
      reuse_rs1    <= issue_rs1;
      reuse_rs2    <= issue_rs2;
      reuse_signed <= is_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      reuse_valid <= 1'b0;
    end else begin
      if (accept)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_take) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop_take})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A simultaneous accept re-arms reuse with the freshly stored operands.
      if (accept)        reuse_valid <= 1'b1;
      else if (rs_write) reuse_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && issue_valid) begin
      assert (issue_fn3[2]) else $error("div_operand_prep: non-divide fn3 issued");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_operand_prep.sv
`default_nettype none
// tb_div_operand_prep: directed table-driven checks plus full/flush sequences.
// Revision 1.0
module tb_div_operand_prep;
  import riscv_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_fn3;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [$bits(div_attributes_t)-1:0]  issue_attr;
  logic        rs_write;
  logic        flush;
  logic        fifo_valid;
  logic        fifo_pop;
  logic [$bits(div_fifo_inputs_t)-1:0] fifo_data;

  div_fifo_inputs_t head;
  assign head = div_fifo_inputs_t'(fifo_data);

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_operand_prep #(.DEPTH(2), .ENABLE_REUSE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_fn3   (issue_fn3),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_attr  (issue_attr),
    .rs_write    (rs_write),
    .flush       (flush),
    .fifo_valid  (fifo_valid),
    .fifo_pop    (fifo_pop),
    .fifo_data   (fifo_data)
  );

  typedef struct {
    logic [2:0]  fn3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] e_dvd;
    logic [31:0] e_dvs;
    logic [4:0]  e_dclz;
    logic [4:0]  e_vclz;
    logic        e_dz;
    logic        e_reuse;
    logic        wr_before;
    logic        wr_during;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [8:0] at);
    issue_fn3   = f;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_attr  = at;
    issue_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          fn3   rs1           rs2           dividend      divisor       dclz   vclz   dz    reuse wrb   wrd
    vecs[0]  = '{DIVU, 32'd100,      32'd7,        32'd100,      32'd7,        5'd25, 5'd29, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{DIV,  32'hFFFFFFF6, 32'h80000000, 32'd10,       32'h80000000, 5'd28, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{REM,  32'd5,        32'd0,        32'd5,        32'd0,        5'd29, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{DIV,  32'd20,       32'd3,        32'd20,       32'd3,        5'd27, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{REM,  32'd20,       32'd3,        32'd20,       32'd3,        5'd27, 5'd30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{DIVU, 32'd20,       32'd3,        32'd20,       32'd3,        5'd27, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{REMU, 32'd20,       32'd3,        32'd20,       32'd3,        5'd27, 5'd30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{REMU, 32'd20,       32'd3,        32'd20,       32'd3,        5'd27, 5'd30, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1,        5'd0,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{DIVU, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 32'h00010000, 5'd0,  5'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{REM,  32'd0,        32'hFFFFFFF9, 32'd0,        32'd7,        5'd31, 5'd29, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{DIV,  32'd0,        32'hFFFFFFF9, 32'd0,        32'd7,        5'd31, 5'd29, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{DIV,  32'd0,        32'hFFFFFFF9, 32'd0,        32'd7,        5'd31, 5'd29, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{DIV,  32'd0,        32'hFFFFFFF9, 32'd0,        32'd7,        5'd31, 5'd29, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; issue_valid = 1'b0; issue_fn3 = 3'b100; issue_rs1 = '0; issue_rs2 = '0;
    issue_attr = '0; rs_write = 1'b0; flush = 1'b0; fifo_pop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_fifo_valid", 64'(fifo_valid), 64'd0);
    check("reset_issue_ready", 64'(issue_ready), 64'd1);

    // One op at a time: issue, see it one cycle later, pop it.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr_before) begin
        rs_write = 1'b1;
        @(negedge clk);
        rs_write = 1'b0;
      end
      drive(vecs[i].fn3, vecs[i].rs1, vecs[i].rs2, 9'(i));
      rs_write = vecs[i].wr_during;
      #1;
      check($sformatf("v%0d_issue_ready", i), 64'(issue_ready), 64'd1);
      @(negedge clk);
      issue_valid = 1'b0;
      rs_write    = 1'b0;
      #1;
      check($sformatf("v%0d_fifo_valid", i), 64'(fifo_valid), 64'd1);
      check($sformatf("v%0d_dividend", i), 64'(head.unsigned_dividend), 64'(vecs[i].e_dvd));
      check($sformatf("v%0d_divisor", i), 64'(head.unsigned_divisor), 64'(vecs[i].e_dvs));
      check($sformatf("v%0d_dividend_clz", i), 64'(head.dividend_CLZ), 64'(vecs[i].e_dclz));
      check($sformatf("v%0d_divisor_clz", i), 64'(head.divisor_CLZ), 64'(vecs[i].e_vclz));
      check($sformatf("v%0d_div_zero", i), 64'(head.divisor_is_zero), 64'(vecs[i].e_dz));
      check($sformatf("v%0d_reuse", i), 64'(head.reuse_result), 64'(vecs[i].e_reuse));
      check($sformatf("v%0d_fn3", i), 64'(head.fn3), 64'(vecs[i].fn3));
      check($sformatf("v%0d_attr", i), 64'(head.attr), 64'(i));
      fifo_pop = 1'b1;
      @(negedge clk);
      fifo_pop = 1'b0;
      #1;
      check($sformatf("v%0d_drained", i), 64'(fifo_valid), 64'd0);
    end

    // Fill to DEPTH, then pop and issue together while full.
    @(negedge clk);
    drive(DIVU, 32'd1, 32'd1, 9'h101);
    @(negedge clk);
    drive(DIVU, 32'd2, 32'd1, 9'h102);
    #1;
    check("full_ready_one_entry", 64'(issue_ready), 64'd1);
    @(negedge clk);
    drive(DIVU, 32'd3, 32'd1, 9'h103);
    #1;
    check("full_ready_blocked", 64'(issue_ready), 64'd0);
    fifo_pop = 1'b1;
    #1;
    check("full_ready_with_pop", 64'(issue_ready), 64'd1);
    check("full_head_first", 64'(head.unsigned_dividend), 64'd1);
    @(negedge clk);
    issue_valid = 1'b0;
    fifo_pop    = 1'b0;
    #1;
    check("full_still_full", 64'(issue_ready), 64'd0);
    check("full_head_second", 64'(head.unsigned_dividend), 64'd2);
    fifo_pop = 1'b1;
    @(negedge clk);
    #1;
    check("full_valid_third", 64'(fifo_valid), 64'd1);
    check("full_head_third", 64'(head.unsigned_dividend), 64'd3);
    @(negedge clk);
    fifo_pop = 1'b0;
    #1;
    check("full_drained", 64'(fifo_valid), 64'd0);

    // Flush with two queued entries; the simultaneous issue and pop are dropped.
    drive(DIV, 32'd40, 32'd6, 9'h040);
    @(negedge clk);
    drive(DIV, 32'd41, 32'd6, 9'h041);
    @(negedge clk);
    drive(DIV, 32'd99, 32'd9, 9'h099);
    flush    = 1'b1;
    fifo_pop = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    fifo_pop    = 1'b0;
    issue_valid = 1'b0;
    #1;
    check("flush_fifo_valid", 64'(fifo_valid), 64'd0);
    check("flush_issue_ready", 64'(issue_ready), 64'd1);
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    #1;
    check("empty_pop_ignored", 64'(fifo_valid), 64'd0);
    drive(DIV, 32'd41, 32'd6, 9'h041);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    check("post_flush_valid", 64'(fifo_valid), 64'd1);
    check("post_flush_dividend", 64'(head.unsigned_dividend), 64'd41);
    check("post_flush_reuse", 64'(head.reuse_result), 64'd0);
    drive(DIV, 32'd41, 32'd6, 9'h042);
    fifo_pop = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    check("post_flush_reuse_rearmed", 64'(head.reuse_result), 64'd1);
    check("post_flush_attr", 64'(head.attr), 64'h042);
    @(negedge clk);
    fifo_pop = 1'b0;
    #1;
    check("final_drained", 64'(fifo_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_operand_prep.md
Name: div_operand_prep

Overview:
- Issue-side front end of the divider. Accepts RV32M divide/remainder requests (fn3 DIV/DIVU/REM/REMU) with raw rs1/rs2 values.
- Registers and preconditions the operands: unsigned magnitudes, leading-zero counts, zero-divisor flag and result-reuse detection.
- Buffers the results in a small FIFO of div_fifo_inputs_t entries that the divider core pops.
- Sits between the issue/register-read stage and the divider core.

Parameters:
- DEPTH, 2, number of FIFO entries; must be a power of two and at least 2.
- ENABLE_REUSE, 1, when 0 the reuse_result field is always 0.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  request present
- issue_ready  out  1  request accepted this cycle when issue_valid is also high
- issue_fn3  in  3  fn3_mul_div_t; only codes 100-111 are legal
- issue_rs1  in  32  dividend, raw register value
- issue_rs2  in  32  divisor, raw register value
- issue_attr  in  $bits(div_attributes_t)  passed through unmodified
- rs_write  in  1  any architectural register write this cycle; breaks reuse
- flush  in  1  pipeline flush
- fifo_valid  out  1  head entry valid
- fifo_pop  in  1  consumer takes the head entry
- fifo_data  out  $bits(div_fifo_inputs_t)  head entry

Behaviour:
- Reset and flush:
  - Reset clears the FIFO (fifo_valid=0, pointers=0, count=0) and clears reuse_valid.
  - Reset and flush do not clear fifo_data; its value is don't-care while fifo_valid=0.
  - issue_ready=1 after reset.
  - flush has the same effect as rst on the FIFO and reuse state.
  - An issue or pop arriving in the same cycle as flush is discarded.
- Handshake:
  - issue_ready = !full || fifo_pop.
  - Accept = issue_valid && issue_ready && !flush.
  - Full and pop in the same cycle allows an accept; count is unchanged.
  - Empty and accept in the same cycle: the entry appears on fifo_valid the next cycle. There is no bypass, so latency is 1 cycle.
  - A pop while fifo_valid=0 is ignored.
  - Pointers wrap modulo DEPTH.
- Signedness: is_signed = !fn3[0] (DIV, REM).
- unsigned_dividend:
  - If is_signed and rs1[31], it is the two's-complement negation of rs1, otherwise rs1.
  - 0x80000000 maps to 0x80000000.
- unsigned_divisor: same rule applied to rs2.
- dividend_CLZ / divisor_CLZ:
  - Leading-zero count of the corresponding unsigned value, 5 bits.
  - A zero value saturates to 31.
- divisor_is_zero: set when rs2 == 0, determined from the raw value.
- Reuse tracking:
  - On each accept, store rs1, rs2 and is_signed, and set reuse_valid.
  - reuse_result = ENABLE_REUSE && reuse_valid && rs1, rs2 and signedness all equal the stored values. The op may differ, e.g. DIV followed by REM.
  - Comparison uses the pre-accept stored values.
  - rs_write clears reuse_valid in the same cycle. If an accept happens in that cycle, the accept's compare still sees the old reuse_valid, and the new operands are then stored with reuse_valid=1 (the accept takes priority).
- attr: copied from issue_attr.
- Illegal fn3 (bit2=0) must not be issued by upstream. Add an assertion only; no other handling.
- Timing: the full per-entry computation is done combinationally on issue_* and written into FIFO storage at accept.

Decomposition:
- The following belong in riscv_types next to div_fifo_inputs_t:
  - DIV_CLZ_W = 5
  - fn3_mul_div_t
- Sub-module: clz32 — combinational 32-bit leading-zero counter with saturate-to-31. It is instantiated twice.
- FIFO storage is inline in this module.

Test Plan:
- DIVU rs1=100, rs2=7 after reset -> one cycle later: fifo_valid=1, unsigned_dividend=100, unsigned_divisor=7, dividend_CLZ=25, divisor_CLZ=29, divisor_is_zero=0, reuse_result=0.
- DIV rs1=0xFFFFFFF6 (-10), rs2=0x80000000 -> unsigned_dividend=10, unsigned_divisor=0x80000000, divisor_CLZ=0, dividend_CLZ=28.
- REM rs1=5, rs2=0 -> divisor_is_zero=1, divisor_CLZ=31.
- DIV 20/3, then REM 20/3 -> second entry reuse_result=1.
  - Repeat with DIVU on the second op -> 0.
  - Repeat with rs_write pulsed between the two ops -> 0.
- DEPTH=2, no pops, three back-to-back issues -> third sees issue_ready=0. Pop and issue in the same cycle while full -> accept; count stays 2; entries come out in order.
- Two entries queued, flush asserted -> fifo_valid=0 next cycle, issue_ready=1. Next identical op has reuse_result=0.
